// File: rtl/display_count_ctrl.sv
// Two-digit display sequencer: start/stop/clear command decode, prescaled decimal/hex
// up/down counter and pause blink for the Go Board seven-segment pair.
module display_count_ctrl #(
    parameter int unsigned CLKS_PER_TICK = 25000000,
    parameter int unsigned BLINK_CLKS    = 6250000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_dir,
    input  logic       i_mode,
    output logic [3:0] o_left_digit,
    output logic [3:0] o_right_digit,
    output logic       o_blank,
    output logic       o_running,
    output logic       o_wrap
);

    localparam int unsigned PreW   = $clog2(CLKS_PER_TICK);
    localparam int unsigned BlinkW = $clog2(BLINK_CLKS);
    localparam logic [PreW-1:0]   PreLast   = PreW'(CLKS_PER_TICK - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CLKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e            state_q;
    logic              ss_prev_q;
    logic              clr_prev_q;
    logic              mode_q;
    logic [PreW-1:0]   pre_q;
    logic [BlinkW-1:0] blink_q;

    logic       ss_cmd;
    logic       clr_cmd;
    logic       tick;
    logic [3:0] nxt_left;
    logic [3:0] nxt_right;
    logic       step_wrap;
    logic [7:0] pair;
    logic [7:0] pair_step;

    assign ss_cmd  = i_start_stop & ~ss_prev_q;
    assign clr_cmd = i_clear & ~clr_prev_q;
    assign tick    = (state_q == StRun) && (pre_q == PreLast);
    assign pair    = {o_left_digit, o_right_digit};

    // Next count value for one step in the current direction and latched mode.
    always_comb begin
        nxt_left  = o_left_digit;
        nxt_right = o_right_digit;
        step_wrap = 1'b0;
        pair_step = i_dir ? (pair - 8'd1) : (pair + 8'd1);
        if (mode_q) begin
            {nxt_left, nxt_right} = pair_step;
            step_wrap = i_dir ? (pair == 8'h00) : (pair == 8'hff);
        end else if (!i_dir) begin
            if (o_right_digit >= 4'd9) begin
                nxt_right = 4'd0;
                if (o_left_digit >= 4'd9) begin
                    nxt_left  = 4'd0;
                    step_wrap = 1'b1;
                end else begin
                    nxt_left = o_left_digit + 4'd1;
                end
            end else begin
                nxt_right = o_right_digit + 4'd1;
            end
        end else begin
            if (o_right_digit == 4'd0) begin
                nxt_right = 4'd9;
                if (o_left_digit == 4'd0) begin
                    nxt_left  = 4'd9;
                    step_wrap = 1'b1;
                end else begin
                    nxt_left = o_left_digit - 4'd1;
                end
            end else begin
                nxt_right = o_right_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            ss_prev_q     <= 1'b1;
            clr_prev_q    <= 1'b1;
            mode_q        <= 1'b0;
            pre_q         <= '0;
            blink_q       <= '0;
            o_left_digit  <= 4'd0;
            o_right_digit <= 4'd0;
            o_blank       <= 1'b0;
            o_running     <= 1'b0;
            o_wrap        <= 1'b0;
        end else begin
            ss_prev_q  <= i_start_stop;
            clr_prev_q <= i_clear;
            o_wrap     <= 1'b0;
            if (clr_cmd) begin
                state_q       <= StIdle;
                pre_q         <= '0;
                blink_q       <= '0;
                o_left_digit  <= 4'd0;
                o_right_digit <= 4'd0;
                o_blank       <= 1'b0;
                o_running     <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (ss_cmd) begin
                            mode_q    <= i_mode;
                            pre_q     <= '0;
                            state_q   <= StRun;
                            o_running <= 1'b1;
                        end
                    end
                    StRun: begin
                        // A tick coinciding with stop is still applied before pausing.
                        if (tick) begin
                            pre_q         <= '0;
                            o_left_digit  <= nxt_left;
                            o_right_digit <= nxt_right;
                            o_wrap        <= step_wrap;
                        end else begin
                            pre_q <= pre_q + PreW'(1);
                        end
                        if (ss_cmd) begin
                            state_q   <= StPause;
                            o_running <= 1'b0;
                            blink_q   <= '0;
                            o_blank   <= 1'b0;
                        end
                    end
                    StPause: begin
                        if (ss_cmd) begin
                            state_q   <= StRun;
                            o_running <= 1'b1;
                            blink_q   <= '0;
                            o_blank   <= 1'b0;
                        end else if (blink_q == BlinkLast) begin
                            blink_q <= '0;
                            o_blank <= ~o_blank;
                        end else begin
                            blink_q <= blink_q + BlinkW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_count_ctrl.sv
// Bench for display_count_ctrl: directed scenarios plus random stimulus against an
// integer-valued reference model of the counter.
module tb_display_count_ctrl;

    localparam int C = 4;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
    logic       dir;
    logic       mode;
    logic [3:0] left_digit;
    logic [3:0] right_digit;
    logic       blank;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    display_count_ctrl #(
        .CLKS_PER_TICK(C),
        .BLINK_CLKS   (B)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_stop (start_stop),
        .i_clear      (clear),
        .i_dir        (dir),
        .i_mode       (mode),
        .o_left_digit (left_digit),
        .o_right_digit(right_digit),
        .o_blank      (blank),
        .o_running    (running),
        .o_wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: state 0 idle, 1 run, 2 pause; count held as an integer.
    int m_state, m_val, m_pre, m_blink;
    bit m_hex, m_blank, m_wrap, m_prev_ss, m_prev_clr;

    function automatic void model_reset();
        m_state = 0; m_val = 0; m_pre = 0; m_blink = 0;
        m_hex = 0; m_blank = 0; m_wrap = 0; m_prev_ss = 1; m_prev_clr = 1;
    endfunction

    function automatic void model_step();
        bit ss_ev, cl_ev;
        int modulus, nv;
        ss_ev = start_stop && !m_prev_ss;
        cl_ev = clear && !m_prev_clr;
        m_prev_ss = start_stop;
        m_prev_clr = clear;
        m_wrap = 0;
        if (cl_ev) begin
            m_state = 0; m_val = 0; m_pre = 0; m_blink = 0; m_blank = 0;
        end else if (m_state == 0) begin
            if (ss_ev) begin
                m_hex = mode; m_state = 1; m_pre = 0;
            end
        end else if (m_state == 1) begin
            if (m_pre == C - 1) begin
                m_pre = 0;
                modulus = m_hex ? 256 : 100;
                nv = dir ? m_val - 1 : m_val + 1;
                if (nv < 0 || nv >= modulus) m_wrap = 1;
                m_val = (nv + modulus) % modulus;
            end else begin
                m_pre++;
            end
            if (ss_ev) begin
                m_state = 2; m_blink = 0; m_blank = 0;
            end
        end else begin
            if (ss_ev) begin
                m_state = 1; m_blink = 0; m_blank = 0;
            end else if (m_blink == B - 1) begin
                m_blink = 0; m_blank = !m_blank;
            end else begin
                m_blink++;
            end
        end
    endfunction

    function automatic logic [7:0] exp_digits();
        if (m_hex) return 8'(m_val);
        return {4'(m_val / 10), 4'(m_val % 10)};
    endfunction

    task automatic clk1();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic do_clear();
        start_stop = 0;
        clear = 1;
        clk1();
        clear = 0;
        clk1();
    endtask

    task automatic do_start();
        start_stop = 1;
        clk1();
        start_stop = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start_stop = 1; clear = 0; dir = 0; mode = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({left_digit, right_digit, blank, running, wrap} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {left_digit, right_digit, blank, running, wrap});
        end
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            clk1();
            checks++;
            if ({left_digit, right_digit, running, wrap} !== 10'd0) begin
                errors++;
                $display("FAIL held_start_no_cmd: cycle %0d got %b want 0", i,
                         {left_digit, right_digit, running, wrap});
            end
        end
        start_stop = 0;
        clk1();
        start_stop = 1;
        clk1();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_after_reedge: running=%b want 1", running);
        end
    endtask

    task automatic test_count_up_wrap();
        do_clear();
        mode = 0; dir = 0;
        do_start();
        run(C);
        checks++;
        if ({left_digit, right_digit} !== 8'h01) begin
            errors++;
            $display("FAIL first_tick: got %h want 01", {left_digit, right_digit});
        end
        run(C);
        checks++;
        if ({left_digit, right_digit} !== 8'h02) begin
            errors++;
            $display("FAIL second_tick: got %h want 02", {left_digit, right_digit});
        end
        run(97 * C);
        checks++;
        if ({left_digit, right_digit, wrap} !== {8'h99, 1'b0}) begin
            errors++;
            $display("FAIL count_99: got %h wrap %b want 99 wrap 0", {left_digit, right_digit}, wrap);
        end
        run(C);
        checks++;
        if ({left_digit, right_digit, wrap} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL dec_wrap_up: got %h wrap %b want 00 wrap 1", {left_digit, right_digit}, wrap);
        end
        clk1();
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_one_cycle: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_hex_down();
        do_clear();
        mode = 1; dir = 1;
        do_start();
        run(C);
        checks++;
        if ({left_digit, right_digit, wrap} !== {8'hff, 1'b1}) begin
            errors++;
            $display("FAIL hex_wrap_down: got %h wrap %b want ff wrap 1", {left_digit, right_digit}, wrap);
        end
        mode = 0;
        run(C);
        checks++;
        if ({left_digit, right_digit, wrap} !== {8'hfe, 1'b0}) begin
            errors++;
            $display("FAIL mode_ignored: got %h wrap %b want fe wrap 0", {left_digit, right_digit}, wrap);
        end
        dir = 0;
    endtask

    task automatic test_pause_blink();
        do_clear();
        mode = 0; dir = 0;
        do_start();
        run(7 * C + 1);
        start_stop = 1;
        clk1();
        start_stop = 0;
        checks++;
        if ({left_digit, right_digit, running} !== {8'h07, 1'b0}) begin
            errors++;
            $display("FAIL pause_at_07: got %h run %b want 07 run 0", {left_digit, right_digit}, running);
        end
        for (int i = 1; i <= 3; i++) begin
            clk1();
            checks++;
            if ({blank, left_digit, right_digit} !== {(i == 3), 8'h07}) begin
                errors++;
                $display("FAIL blink_%0d: got blank %b digits %h want blank %b digits 07", i, blank,
                         {left_digit, right_digit}, (i == 3));
            end
        end
        start_stop = 1;
        clk1();
        start_stop = 0;
        checks++;
        if ({blank, running} !== 2'b01) begin
            errors++;
            $display("FAIL resume_unblank: got blank %b run %b want 0 1", blank, running);
        end
        clk1();
        checks++;
        if ({left_digit, right_digit} !== 8'h07) begin
            errors++;
            $display("FAIL resume_hold: got %h want 07", {left_digit, right_digit});
        end
        clk1();
        checks++;
        if ({left_digit, right_digit} !== 8'h08) begin
            errors++;
            $display("FAIL resume_remaining: got %h want 08", {left_digit, right_digit});
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        mode = 0; dir = 0;
        do_start();
        run(100 * C - 1);
        checks++;
        if ({left_digit, right_digit} !== 8'h99) begin
            errors++;
            $display("FAIL pre_clear_99: got %h want 99", {left_digit, right_digit});
        end
        clear = 1; start_stop = 1;
        clk1();
        clear = 0; start_stop = 0;
        checks++;
        if ({left_digit, right_digit, wrap, running} !== 10'd0) begin
            errors++;
            $display("FAIL clear_wins: got %h wrap %b run %b want 00 0 0", {left_digit, right_digit},
                     wrap, running);
        end
        run(2 * C);
        checks++;
        if ({left_digit, right_digit, running, blank} !== 10'd0) begin
            errors++;
            $display("FAIL stays_idle: got %h run %b blank %b want 00 0 0", {left_digit, right_digit},
                     running, blank);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        mode = 0; dir = 0;
        do_start();
        run(41 * C + C - 1);
        start_stop = 1;
        clk1();
        start_stop = 0;
        checks++;
        if ({left_digit, right_digit, running} !== {8'h42, 1'b0}) begin
            errors++;
            $display("FAIL tick_and_stop: got %h run %b want 42 run 0", {left_digit, right_digit}, running);
        end
        run(B);
        checks++;
        if ({blank, left_digit, right_digit} !== {1'b1, 8'h42}) begin
            errors++;
            $display("FAIL paused_after_stop: got blank %b digits %h want 1 42", blank,
                     {left_digit, right_digit});
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(39) == 0) start_stop = ~start_stop;
            clear = ($urandom_range(299) == 0);
            if ($urandom_range(149) == 0) dir = ~dir;
            mode = 1'($urandom_range(1));
            clk1();
            checks++;
            if ({left_digit, right_digit} !== exp_digits()) begin
                errors++;
                $display("FAIL rand_digits: cycle %0d got %h want %h", i, {left_digit, right_digit},
                         exp_digits());
            end
            checks++;
            if ({blank, running, wrap} !== {m_blank, (m_state == 1), m_wrap}) begin
                errors++;
                $display("FAIL rand_flags: cycle %0d got blank/run/wrap %b want %b", i,
                         {blank, running, wrap}, {m_blank, (m_state == 1), m_wrap});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        mode = 0; dir = 0;
        do_start();
        run(3 * C + 2);
        @(posedge clk);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({left_digit, right_digit, blank, running, wrap} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0", {left_digit, right_digit, blank, running, wrap});
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        run(2 * C);
        checks++;
        if ({left_digit, right_digit, running} !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h run %b want 00 0", {left_digit, right_digit}, running);
        end
    endtask

    initial begin
        test_reset();
        test_count_up_wrap();
        test_hex_down();
        test_pause_blink();
        test_clear_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
